// File: rtl/pix_addr_gen.sv
// Two-stage raster-to-image address generator: window test, integer upscale and
// page base, with scale/base captured only at frame start so a frame never tears.
module pix_addr_gen #(
    parameter int ROW_W     = 10,
    parameter int COL_W     = 11,
    parameter int X_BITS    = 8,
    parameter int Y_BITS    = 8,
    parameter int ROW_OFS   = 35,
    parameter int COL_OFS   = 216,
    parameter int SCALE_RST = 1,
    localparam int ADDR_W   = X_BITS + Y_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic [ROW_W-1:0]  fila,
    input  logic [COL_W-1:0]  columna,
    input  logic [1:0]        scale_sel,
    input  logic [ADDR_W-1:0] base_in,
    output logic [ADDR_W-1:0] addr,
    output logic              in_img,
    output logic              frame_start
);

    // Three guard bits keep the offset subtraction signed and the 4x limit unwrapped.
    localparam int DW = ((ROW_W > COL_W) ? ROW_W : COL_W) + 3;

    localparam logic signed [DW-1:0] COL_OFS_S = DW'(COL_OFS);
    localparam logic signed [DW-1:0] ROW_OFS_S = DW'(ROW_OFS);
    localparam logic signed [DW-1:0] X_SPAN    = DW'(2 ** X_BITS);
    localparam logic signed [DW-1:0] Y_SPAN    = DW'(2 ** Y_BITS);

    logic [1:0]        scale_q;
    logic [ADDR_W-1:0] base_q;

    logic              fs_now;
    logic [1:0]        scale_eff;
    logic [ADDR_W-1:0] base_eff;
    logic signed [DW-1:0] dx, dy, x_lim, y_lim;
    logic              win;

    logic [X_BITS-1:0] s1_x;
    logic [Y_BITS-1:0] s1_y;
    logic              s1_win;
    logic              s1_fs;
    logic [ADDR_W-1:0] s1_base;

    assign fs_now = (fila == '0) && (columna == '0);

    // The pixel that opens a frame already uses the newly requested scale and base.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        scale_eff = scale_q;
        base_eff  = base_q;
        if (fs_now) begin
            base_eff = base_in;
            if (scale_sel != 2'd3) begin
                scale_eff = scale_sel;
            end
        end
    end

    assign dx    = $signed({{(DW-COL_W){1'b0}}, columna}) - COL_OFS_S;
    assign dy    = $signed({{(DW-ROW_W){1'b0}}, fila}) - ROW_OFS_S;
    assign x_lim = X_SPAN << scale_eff;
    assign y_lim = Y_SPAN << scale_eff;
    assign win   = !dx[DW-1] && (dx < x_lim) && !dy[DW-1] && (dy < y_lim);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register
        // samples pre-edge values and stage order inside the block does not matter.
        if (reset) begin
            scale_q     <= 2'(SCALE_RST);
            base_q      <= '0;
            s1_x        <= '0;
            s1_y        <= '0;
            s1_win      <= 1'b0;
            s1_fs       <= 1'b0;
            s1_base     <= '0;
            addr        <= '0;
            in_img      <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            if (fs_now) begin
                scale_q <= scale_eff;
                base_q  <= base_in;
            end
            s1_x    <= X_BITS'(dx >> scale_eff);
            s1_y    <= Y_BITS'(dy >> scale_eff);
            s1_win  <= win;
            s1_fs   <= fs_now;
            s1_base <= base_eff;

            // Base addition wraps modulo the address space by design.
            addr        <= s1_win ? (s1_base + {s1_y, s1_x}) : '0;
            in_img      <= s1_win;
            frame_start <= s1_fs;
        end
    end

endmodule

// File: tb/tb_pix_addr_gen.sv
// Self-checking bench for pix_addr_gen: directed scenarios followed by randomized
// traffic, all compared against an arithmetic reference model.
module tb_pix_addr_gen;

    localparam int ROW_W     = 10;
    localparam int COL_W     = 11;
    localparam int X_BITS    = 8;
    localparam int Y_BITS    = 8;
    localparam int ROW_OFS   = 35;
    localparam int COL_OFS   = 216;
    localparam int SCALE_RST = 1;
    localparam int ADDR_W    = X_BITS + Y_BITS;

    logic              clk = 1'b0;
    logic              reset;
    logic              pix_en;
    logic [ROW_W-1:0]  fila;
    logic [COL_W-1:0]  columna;
    logic [1:0]        scale_sel;
    logic [ADDR_W-1:0] base_in;
    logic [ADDR_W-1:0] addr;
    logic              in_img;
    logic              frame_start;

    always #5 clk = ~clk;

    pix_addr_gen #(
        .ROW_W(ROW_W), .COL_W(COL_W), .X_BITS(X_BITS), .Y_BITS(Y_BITS),
        .ROW_OFS(ROW_OFS), .COL_OFS(COL_OFS), .SCALE_RST(SCALE_RST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pix_en(pix_en),
        .fila(fila),
        .columna(columna),
        .scale_sel(scale_sel),
        .base_in(base_in),
        .addr(addr),
        .in_img(in_img),
        .frame_start(frame_start)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: magnification factor and page base in effect for the frame,
    // plus the result of the pixel in flight and the result now due at the outputs.
    int fact_tab [3] = '{1, 2, 4};
    int m_fact;
    int m_base;
    int s1_a, s1_img, s1_fs;
    int o_a, o_img, o_fs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_map(input int f, input int c, input int fact, input int base,
                                    output int a, output int img);
        int dx, dy, w, h;
        dx = c - COL_OFS;
        dy = f - ROW_OFS;
        w  = (2 ** X_BITS) * fact;
        h  = (2 ** Y_BITS) * fact;
        if (dx >= 0 && dx < w && dy >= 0 && dy < h) begin
            img = 1;
            a   = (base + (dy / fact) * (2 ** X_BITS) + (dx / fact)) % (2 ** ADDR_W);
        end else begin
            img = 0;
            a   = 0;
        end
    endfunction

    task automatic drive(input logic pe, input int f, input int c);
        pix_en  = pe;
        fila    = ROW_W'(f);
        columna = COL_W'(c);
    endtask

    // One clock: update the model with the inputs the DUT samples, then compare outputs.
    task automatic tick();
        int fs;
        @(posedge clk);
        if (reset) begin
            m_fact = fact_tab[SCALE_RST];
            m_base = 0;
            s1_a = 0; s1_img = 0; s1_fs = 0;
            o_a  = 0; o_img  = 0; o_fs  = 0;
        end else if (pix_en) begin
            fs = (int'(fila) == 0 && int'(columna) == 0) ? 1 : 0;
            if (fs == 1) begin
                if (scale_sel != 2'd3) m_fact = fact_tab[scale_sel];
                m_base = int'(base_in);
            end
            o_a = s1_a; o_img = s1_img; o_fs = s1_fs;
            ref_map(int'(fila), int'(columna), m_fact, m_base, s1_a, s1_img);
            s1_fs = fs;
        end
        #1;
        check("addr_model", 32'(addr), o_a);
        check("in_img_model", 32'(in_img), o_img);
        check("frame_start_model", 32'(frame_start), o_fs);
    endtask

    initial begin
        m_fact = fact_tab[SCALE_RST];
        m_base = 0;
        s1_a = 0; s1_img = 0; s1_fs = 0;
        o_a  = 0; o_img  = 0; o_fs  = 0;

        // Reset held two clocks with a valid in-window pixel presented.
        reset = 1'b1; scale_sel = 2'd0; base_in = '0;
        drive(1'b1, 35, 216);
        tick();
        tick();
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_in_img", 32'(in_img), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        reset = 1'b0;

        // 2x mapping.
        scale_sel = 2'd1; base_in = '0;
        drive(1'b1, 0, 0);     tick();
        drive(1'b1, 35, 216);  tick();
        check("fs_pulse_2x", 32'(frame_start), 32'h1);
        drive(1'b1, 36, 219);  tick();
        check("map2x_a_addr", 32'(addr), 32'h0000);
        check("map2x_a_img", 32'(in_img), 32'h1);
        drive(1'b1, 37, 218);  tick();
        check("map2x_b_addr", 32'(addr), 32'h0001);
        drive(1'b1, 35, 727);  tick();
        check("map2x_c_addr", 32'(addr), 32'h0101);

        // Window edges at 2x.
        drive(1'b1, 35, 728);  tick();
        check("edge_col727_img", 32'(in_img), 32'h1);
        check("edge_col727_addr", 32'(addr), 32'h00FF);
        drive(1'b1, 34, 216);  tick();
        check("edge_col728_img", 32'(in_img), 32'h0);
        check("edge_col728_addr", 32'(addr), 32'h0);
        drive(1'b1, 546, 216); tick();
        check("edge_row34_img", 32'(in_img), 32'h0);
        scale_sel = 2'd0;
        drive(1'b1, 100, 300); tick();
        check("edge_row546_img", 32'(in_img), 32'h1);
        check("edge_row546_addr", 32'(addr), 32'hFF00);

        // Scale request mid-frame is ignored; takes effect at the next frame start.
        drive(1'b1, 0, 0);     tick();
        check("midframe_scale_ignored", 32'(addr), 32'h202A);
        drive(1'b1, 35, 217);  tick();
        check("fs_pulse_1x", 32'(frame_start), 32'h1);
        scale_sel = 2'd3;
        drive(1'b1, 0, 0);     tick();
        check("map1x_addr", 32'(addr), 32'h0001);
        drive(1'b1, 35, 217);  tick();
        drive(1'b1, 200, 200); tick();
        check("reserved_keeps_1x", 32'(addr), 32'h0001);

        // Base wrap at 1x; base/scale requests outside frame start are ignored.
        scale_sel = 2'd0; base_in = 16'hFFFF;
        drive(1'b1, 0, 0);     tick();
        check("fs_not_early", 32'(frame_start), 32'h0);
        scale_sel = 2'd1; base_in = 16'h0000;
        drive(1'b1, 35, 217);  tick();
        check("fs_once_on", 32'(frame_start), 32'h1);
        drive(1'b1, 36, 216);  tick();
        check("fs_once_off", 32'(frame_start), 32'h0);
        check("base_wrap_addr", 32'(addr), 32'h0000);
        check("base_wrap_img", 32'(in_img), 32'h1);
        drive(1'b1, 50, 250);  tick();
        check("base_row1_addr", 32'(addr), 32'h00FF);

        // Stall: outputs hold while pix_en is low.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 60 + i, 260 + i);
            tick();
            check("stall_addr", 32'(addr), 32'h00FF);
            check("stall_img", 32'(in_img), 32'h1);
        end
        drive(1'b1, 60, 260);  tick();
        check("after_stall_addr", 32'(addr), 32'h0F21);

        // Reset mid-frame flushes and restores the reset scale.
        reset = 1'b1;          tick();
        check("midrst_addr", 32'(addr), 32'h0);
        check("midrst_img", 32'(in_img), 32'h0);
        reset = 1'b0;
        drive(1'b1, 37, 218);  tick();
        drive(1'b1, 38, 220);  tick();
        check("post_rst_2x", 32'(addr), 32'h0101);
        scale_sel = 2'd3; base_in = 16'h0000;
        drive(1'b1, 0, 0);     tick();
        drive(1'b1, 37, 218);  tick();
        drive(1'b1, 10, 10);   tick();
        check("next_frame_2x", 32'(addr), 32'h0101);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom % 300) == 0;
            scale_sel = 2'($urandom % 4);
            base_in   = ADDR_W'($urandom);
            if (($urandom % 60) == 0)
                drive(($urandom % 4) != 0, 0, 0);
            else
                drive(($urandom % 4) != 0, $urandom_range(0, 600), $urandom_range(0, 1100));
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
